// File: rtl/aes128_key_expand_if.sv
// Request/readout bundle between the AES-128 key-schedule unit and its consumer.
// Key and round-key buses are [0:127] with bit 0 as the MSB.
interface aes128_key_expand_if;
    logic         start;
    logic [0:127] key;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic [3:0]   rk_addr;
    logic [0:127] rk_data;

    modport master (
        output start, key, rk_addr,
        input  busy, done, keys_valid, rk_data
    );

    modport slave (
        input  start, key, rk_addr,
        output busy, done, keys_valid, rk_data
    );
endinterface

// File: rtl/aes128_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry
// register file, read back through a registered port by round index.
module aes_sbox (
    input  logic [7:0] i_a,
    output logic [7:0] o_s
);
    // FIPS-197 forward S-box lookup
    always_comb begin
        o_s = 8'h00;
        case (i_a)
            8'h00: o_s = 8'h63; 8'h01: o_s = 8'h7c; 8'h02: o_s = 8'h77; 8'h03: o_s = 8'h7b; 8'h04: o_s = 8'hf2; 8'h05: o_s = 8'h6b; 8'h06: o_s = 8'h6f; 8'h07: o_s = 8'hc5;
            8'h08: o_s = 8'h30; 8'h09: o_s = 8'h01; 8'h0a: o_s = 8'h67; 8'h0b: o_s = 8'h2b; 8'h0c: o_s = 8'hfe; 8'h0d: o_s = 8'hd7; 8'h0e: o_s = 8'hab; 8'h0f: o_s = 8'h76;
            8'h10: o_s = 8'hca; 8'h11: o_s = 8'h82; 8'h12: o_s = 8'hc9; 8'h13: o_s = 8'h7d; 8'h14: o_s = 8'hfa; 8'h15: o_s = 8'h59; 8'h16: o_s = 8'h47; 8'h17: o_s = 8'hf0;
            8'h18: o_s = 8'had; 8'h19: o_s = 8'hd4; 8'h1a: o_s = 8'ha2; 8'h1b: o_s = 8'haf; 8'h1c: o_s = 8'h9c; 8'h1d: o_s = 8'ha4; 8'h1e: o_s = 8'h72; 8'h1f: o_s = 8'hc0;
            8'h20: o_s = 8'hb7; 8'h21: o_s = 8'hfd; 8'h22: o_s = 8'h93; 8'h23: o_s = 8'h26; 8'h24: o_s = 8'h36; 8'h25: o_s = 8'h3f; 8'h26: o_s = 8'hf7; 8'h27: o_s = 8'hcc;
            8'h28: o_s = 8'h34; 8'h29: o_s = 8'ha5; 8'h2a: o_s = 8'he5; 8'h2b: o_s = 8'hf1; 8'h2c: o_s = 8'h71; 8'h2d: o_s = 8'hd8; 8'h2e: o_s = 8'h31; 8'h2f: o_s = 8'h15;
            8'h30: o_s = 8'h04; 8'h31: o_s = 8'hc7; 8'h32: o_s = 8'h23; 8'h33: o_s = 8'hc3; 8'h34: o_s = 8'h18; 8'h35: o_s = 8'h96; 8'h36: o_s = 8'h05; 8'h37: o_s = 8'h9a;
            8'h38: o_s = 8'h07; 8'h39: o_s = 8'h12; 8'h3a: o_s = 8'h80; 8'h3b: o_s = 8'he2; 8'h3c: o_s = 8'heb; 8'h3d: o_s = 8'h27; 8'h3e: o_s = 8'hb2; 8'h3f: o_s = 8'h75;
            8'h40: o_s = 8'h09; 8'h41: o_s = 8'h83; 8'h42: o_s = 8'h2c; 8'h43: o_s = 8'h1a; 8'h44: o_s = 8'h1b; 8'h45: o_s = 8'h6e; 8'h46: o_s = 8'h5a; 8'h47: o_s = 8'ha0;
            8'h48: o_s = 8'h52; 8'h49: o_s = 8'h3b; 8'h4a: o_s = 8'hd6; 8'h4b: o_s = 8'hb3; 8'h4c: o_s = 8'h29; 8'h4d: o_s = 8'he3; 8'h4e: o_s = 8'h2f; 8'h4f: o_s = 8'h84;
            8'h50: o_s = 8'h53; 8'h51: o_s = 8'hd1; 8'h52: o_s = 8'h00; 8'h53: o_s = 8'hed; 8'h54: o_s = 8'h20; 8'h55: o_s = 8'hfc; 8'h56: o_s = 8'hb1; 8'h57: o_s = 8'h5b;
            8'h58: o_s = 8'h6a; 8'h59: o_s = 8'hcb; 8'h5a: o_s = 8'hbe; 8'h5b: o_s = 8'h39; 8'h5c: o_s = 8'h4a; 8'h5d: o_s = 8'h4c; 8'h5e: o_s = 8'h58; 8'h5f: o_s = 8'hcf;
            8'h60: o_s = 8'hd0; 8'h61: o_s = 8'hef; 8'h62: o_s = 8'haa; 8'h63: o_s = 8'hfb; 8'h64: o_s = 8'h43; 8'h65: o_s = 8'h4d; 8'h66: o_s = 8'h33; 8'h67: o_s = 8'h85;
            8'h68: o_s = 8'h45; 8'h69: o_s = 8'hf9; 8'h6a: o_s = 8'h02; 8'h6b: o_s = 8'h7f; 8'h6c: o_s = 8'h50; 8'h6d: o_s = 8'h3c; 8'h6e: o_s = 8'h9f; 8'h6f: o_s = 8'ha8;
            8'h70: o_s = 8'h51; 8'h71: o_s = 8'ha3; 8'h72: o_s = 8'h40; 8'h73: o_s = 8'h8f; 8'h74: o_s = 8'h92; 8'h75: o_s = 8'h9d; 8'h76: o_s = 8'h38; 8'h77: o_s = 8'hf5;
            8'h78: o_s = 8'hbc; 8'h79: o_s = 8'hb6; 8'h7a: o_s = 8'hda; 8'h7b: o_s = 8'h21; 8'h7c: o_s = 8'h10; 8'h7d: o_s = 8'hff; 8'h7e: o_s = 8'hf3; 8'h7f: o_s = 8'hd2;
            8'h80: o_s = 8'hcd; 8'h81: o_s = 8'h0c; 8'h82: o_s = 8'h13; 8'h83: o_s = 8'hec; 8'h84: o_s = 8'h5f; 8'h85: o_s = 8'h97; 8'h86: o_s = 8'h44; 8'h87: o_s = 8'h17;
            8'h88: o_s = 8'hc4; 8'h89: o_s = 8'ha7; 8'h8a: o_s = 8'h7e; 8'h8b: o_s = 8'h3d; 8'h8c: o_s = 8'h64; 8'h8d: o_s = 8'h5d; 8'h8e: o_s = 8'h19; 8'h8f: o_s = 8'h73;
            8'h90: o_s = 8'h60; 8'h91: o_s = 8'h81; 8'h92: o_s = 8'h4f; 8'h93: o_s = 8'hdc; 8'h94: o_s = 8'h22; 8'h95: o_s = 8'h2a; 8'h96: o_s = 8'h90; 8'h97: o_s = 8'h88;
            8'h98: o_s = 8'h46; 8'h99: o_s = 8'hee; 8'h9a: o_s = 8'hb8; 8'h9b: o_s = 8'h14; 8'h9c: o_s = 8'hde; 8'h9d: o_s = 8'h5e; 8'h9e: o_s = 8'h0b; 8'h9f: o_s = 8'hdb;
            8'ha0: o_s = 8'he0; 8'ha1: o_s = 8'h32; 8'ha2: o_s = 8'h3a; 8'ha3: o_s = 8'h0a; 8'ha4: o_s = 8'h49; 8'ha5: o_s = 8'h06; 8'ha6: o_s = 8'h24; 8'ha7: o_s = 8'h5c;
            8'ha8: o_s = 8'hc2; 8'ha9: o_s = 8'hd3; 8'haa: o_s = 8'hac; 8'hab: o_s = 8'h62; 8'hac: o_s = 8'h91; 8'had: o_s = 8'h95; 8'hae: o_s = 8'he4; 8'haf: o_s = 8'h79;
            8'hb0: o_s = 8'he7; 8'hb1: o_s = 8'hc8; 8'hb2: o_s = 8'h37; 8'hb3: o_s = 8'h6d; 8'hb4: o_s = 8'h8d; 8'hb5: o_s = 8'hd5; 8'hb6: o_s = 8'h4e; 8'hb7: o_s = 8'ha9;
            8'hb8: o_s = 8'h6c; 8'hb9: o_s = 8'h56; 8'hba: o_s = 8'hf4; 8'hbb: o_s = 8'hea; 8'hbc: o_s = 8'h65; 8'hbd: o_s = 8'h7a; 8'hbe: o_s = 8'hae; 8'hbf: o_s = 8'h08;
            8'hc0: o_s = 8'hba; 8'hc1: o_s = 8'h78; 8'hc2: o_s = 8'h25; 8'hc3: o_s = 8'h2e; 8'hc4: o_s = 8'h1c; 8'hc5: o_s = 8'ha6; 8'hc6: o_s = 8'hb4; 8'hc7: o_s = 8'hc6;
            8'hc8: o_s = 8'he8; 8'hc9: o_s = 8'hdd; 8'hca: o_s = 8'h74; 8'hcb: o_s = 8'h1f; 8'hcc: o_s = 8'h4b; 8'hcd: o_s = 8'hbd; 8'hce: o_s = 8'h8b; 8'hcf: o_s = 8'h8a;
            8'hd0: o_s = 8'h70; 8'hd1: o_s = 8'h3e; 8'hd2: o_s = 8'hb5; 8'hd3: o_s = 8'h66; 8'hd4: o_s = 8'h48; 8'hd5: o_s = 8'h03; 8'hd6: o_s = 8'hf6; 8'hd7: o_s = 8'h0e;
            8'hd8: o_s = 8'h61; 8'hd9: o_s = 8'h35; 8'hda: o_s = 8'h57; 8'hdb: o_s = 8'hb9; 8'hdc: o_s = 8'h86; 8'hdd: o_s = 8'hc1; 8'hde: o_s = 8'h1d; 8'hdf: o_s = 8'h9e;
            8'he0: o_s = 8'he1; 8'he1: o_s = 8'hf8; 8'he2: o_s = 8'h98; 8'he3: o_s = 8'h11; 8'he4: o_s = 8'h69; 8'he5: o_s = 8'hd9; 8'he6: o_s = 8'h8e; 8'he7: o_s = 8'h94;
            8'he8: o_s = 8'h9b; 8'he9: o_s = 8'h1e; 8'hea: o_s = 8'h87; 8'heb: o_s = 8'he9; 8'hec: o_s = 8'hce; 8'hed: o_s = 8'h55; 8'hee: o_s = 8'h28; 8'hef: o_s = 8'hdf;
            8'hf0: o_s = 8'h8c; 8'hf1: o_s = 8'ha1; 8'hf2: o_s = 8'h89; 8'hf3: o_s = 8'h0d; 8'hf4: o_s = 8'hbf; 8'hf5: o_s = 8'he6; 8'hf6: o_s = 8'h42; 8'hf7: o_s = 8'h68;
            8'hf8: o_s = 8'h41; 8'hf9: o_s = 8'h99; 8'hfa: o_s = 8'h2d; 8'hfb: o_s = 8'h0f; 8'hfc: o_s = 8'hb0; 8'hfd: o_s = 8'h54; 8'hfe: o_s = 8'hbb; 8'hff: o_s = 8'h16;
            default: o_s = 8'h00;
        endcase
    end
endmodule

module aes128_key_expand (
    input  logic                 clk,
    input  logic                 reset,
    aes128_key_expand_if.slave   bus
);
    typedef enum logic {S_IDLE = 1'b0, S_EXPAND = 1'b1} state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [3:0]   r_cnt;
    logic [0:127] r_rk [0:10];
    logic         r_done;
    logic         r_keys_valid;
    logic [0:127] r_rk_data;

    logic [3:0]   w_prev_idx;
    logic [0:127] w_prev;
    logic [0:31]  w_w3;
    logic [0:31]  w_rot;
    logic [0:31]  w_sub;
    logic [0:31]  w_t;
    logic [0:31]  w_n0, w_n1, w_n2, w_n3;
    logic [0:127] w_new;
    logic [0:127] w_rd;

    function automatic logic [7:0] rcon_f(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // cnt is 0 or 11 outside an expansion; clamp so the array index stays in range
    assign w_prev_idx = (r_cnt >= 4'd1 && r_cnt <= 4'd11) ? (r_cnt - 4'd1) : 4'd0;
    assign w_prev     = r_rk[w_prev_idx];
    assign w_w3       = w_prev[96:127];
    assign w_rot      = {w_w3[8:31], w_w3[0:7]};

    aes_sbox u_sb0 (.i_a(w_rot[0:7]),   .o_s(w_sub[0:7]));
    aes_sbox u_sb1 (.i_a(w_rot[8:15]),  .o_s(w_sub[8:15]));
    aes_sbox u_sb2 (.i_a(w_rot[16:23]), .o_s(w_sub[16:23]));
    aes_sbox u_sb3 (.i_a(w_rot[24:31]), .o_s(w_sub[24:31]));

    assign w_t   = w_sub ^ {rcon_f(r_cnt), 24'h000000};
    assign w_n0  = w_prev[0:31]  ^ w_t;
    assign w_n1  = w_prev[32:63] ^ w_n0;
    assign w_n2  = w_prev[64:95] ^ w_n1;
    assign w_n3  = w_w3          ^ w_n2;
    assign w_new = {w_n0, w_n1, w_n2, w_n3};
    assign w_rd  = (bus.rk_addr <= 4'd10) ? r_rk[bus.rk_addr] : 128'h0;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: accept start only when idle, leave EXPAND after round 10
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_nxt = S_EXPAND;
                else           w_state_nxt = S_IDLE;
            end
            S_EXPAND: begin
                if (r_cnt == 4'd10) w_state_nxt = S_IDLE;
                else                w_state_nxt = S_EXPAND;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Round-key file, counter, status flags and registered read port
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= 4'd0;
            r_done       <= 1'b0;
            r_keys_valid <= 1'b0;
            r_rk_data    <= 128'h0;
            for (int i = 0; i < 11; i++) r_rk[i] <= 128'h0;
        end else begin
            r_done    <= 1'b0;
            r_rk_data <= w_rd;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_rk[0]      <= bus.key;
                        r_cnt        <= 4'd1;
                        r_keys_valid <= 1'b0;
                    end
                end
                S_EXPAND: begin
                    r_rk[r_cnt] <= w_new;
                    r_cnt       <= r_cnt + 4'd1;
                    if (r_cnt == 4'd10) begin
                        r_done       <= 1'b1;
                        r_keys_valid <= 1'b1;
                    end
                end
                default: r_cnt <= 4'd0;
            endcase
        end
    end

    assign bus.busy       = (r_state == S_EXPAND);
    assign bus.done       = r_done;
    assign bus.keys_valid = r_keys_valid;
    assign bus.rk_data    = r_rk_data;
endmodule

// File: tb/tb_aes128_key_expand.sv
// Directed bench for aes128_key_expand using FIPS-197 key-schedule vectors.
module tb_aes128_key_expand;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    aes128_key_expand_if bus();

    aes128_key_expand dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [0:127] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    logic [0:127] fips_rk [0:10];

    // Each call leaves the bench at the falling edge right after the accept edge E0.
    task automatic start_key(input logic [0:127] k);
        @(negedge clk);
        bus.key   = k;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus.start   = 1'b1;
        bus.key     = FIPS_KEY;
        bus.rk_addr = 4'd0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.keys_valid !== 1'b0) begin n_err++; $display("FAIL reset_keys_valid: got %b want 0", bus.keys_valid); end
        n_cmp++; if (bus.rk_data !== 128'h0) begin n_err++; $display("FAIL reset_rk_data: got %h want 0", bus.rk_data); end
        reset     = 1'b0;
        bus.start = 1'b0;
        for (int a = 0; a <= 10; a++) begin
            bus.rk_addr = 4'(a);
            @(negedge clk);
            n_cmp++; if (bus.rk_data !== 128'h0) begin n_err++; $display("FAIL reset_rk%0d: got %h want 0", a, bus.rk_data); end
        end
    endtask

    task automatic test_fips();
        int done_cnt;
        int done_at;
        int addrs [3];
        done_cnt = 0;
        done_at  = -1;
        addrs    = '{0, 1, 10};
        start_key(FIPS_KEY);
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL fips_busy_e0: got %b want 1", bus.busy); end
        n_cmp++; if (bus.keys_valid !== 1'b0) begin n_err++; $display("FAIL fips_kv_e0: got %b want 0", bus.keys_valid); end
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
            if (n == 10) begin
                n_cmp++; if (bus.keys_valid !== 1'b1) begin n_err++; $display("FAIL fips_kv_e10: got %b want 1", bus.keys_valid); end
                n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL fips_busy_e10: got %b want 0", bus.busy); end
            end
        end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL fips_done_count: got %0d want 1", done_cnt); end
        n_cmp++; if (done_at !== 10) begin n_err++; $display("FAIL fips_done_edge: got %0d want 10", done_at); end
        for (int i = 0; i < 3; i++) begin
            bus.rk_addr = 4'(addrs[i]);
            @(negedge clk);
            n_cmp++; if (bus.rk_data !== fips_rk[addrs[i]]) begin n_err++; $display("FAIL fips_rk%0d: got %h want %h", addrs[i], bus.rk_data, fips_rk[addrs[i]]); end
        end
    endtask

    task automatic test_reverse_readout();
        int a_cur;
        logic [0:127] exp_v;
        a_cur = 10;
        bus.rk_addr = 4'(a_cur);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            exp_v = (a_cur <= 10) ? fips_rk[a_cur] : 128'h0;
            n_cmp++; if (bus.rk_data !== exp_v) begin n_err++; $display("FAIL rev_rk%0d: got %h want %h", a_cur, bus.rk_data, exp_v); end
            a_cur = (a_cur == 0) ? 15 : a_cur - 1;
            bus.rk_addr = 4'(a_cur);
        end
    endtask

    task automatic test_start_while_busy();
        start_key(FIPS_KEY);
        repeat (2) @(negedge clk);
        bus.key   = 128'h0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL swb_busy_e3: got %b want 1", bus.busy); end
        repeat (7) @(negedge clk);
        n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL swb_done_e10: got %b want 1", bus.done); end
        bus.rk_addr = 4'd1;
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL swb_busy_e11: got %b want 0", bus.busy); end
        n_cmp++; if (bus.rk_data !== fips_rk[1]) begin n_err++; $display("FAIL swb_rk1: got %h want %h", bus.rk_data, fips_rk[1]); end
        bus.rk_addr = 4'd10;
        @(negedge clk);
        n_cmp++; if (bus.rk_data !== fips_rk[10]) begin n_err++; $display("FAIL swb_rk10: got %h want %h", bus.rk_data, fips_rk[10]); end
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        done_cnt = 0;
        bus.rk_addr = 4'd10;
        start_key(FIPS_KEY);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rmid_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.keys_valid !== 1'b0) begin n_err++; $display("FAIL rmid_kv: got %b want 0", bus.keys_valid); end
        n_cmp++; if (bus.rk_data !== 128'h0) begin n_err++; $display("FAIL rmid_rk_data: got %h want 0", bus.rk_data); end
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_cnt++;
        end
        n_cmp++; if (done_cnt !== 0) begin n_err++; $display("FAIL rmid_no_done: got %0d want 0", done_cnt); end
        n_cmp++; if (bus.keys_valid !== 1'b0) begin n_err++; $display("FAIL rmid_kv_after: got %b want 0", bus.keys_valid); end
        start_key(SEQ_KEY);
        repeat (10) @(negedge clk);
        n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL seq_done: got %b want 1", bus.done); end
        n_cmp++; if (bus.keys_valid !== 1'b1) begin n_err++; $display("FAIL seq_kv: got %b want 1", bus.keys_valid); end
        @(negedge clk);
        n_cmp++; if (bus.rk_data !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin n_err++; $display("FAIL seq_rk10: got %h want 13111d7fe3944a17f307a78b4d2b30c5", bus.rk_data); end
    endtask

    task automatic test_rekey();
        n_cmp++; if (bus.keys_valid !== 1'b1) begin n_err++; $display("FAIL rekey_kv_before: got %b want 1", bus.keys_valid); end
        start_key(128'h0);
        n_cmp++; if (bus.keys_valid !== 1'b0) begin n_err++; $display("FAIL rekey_kv_drop: got %b want 0", bus.keys_valid); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rekey_busy: got %b want 1", bus.busy); end
        repeat (9) @(negedge clk);
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rekey_done_e9: got %b want 0", bus.done); end
        bus.rk_addr = 4'd1;
        @(negedge clk);
        n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL rekey_done_e10: got %b want 1", bus.done); end
        n_cmp++; if (bus.keys_valid !== 1'b1) begin n_err++; $display("FAIL rekey_kv_e10: got %b want 1", bus.keys_valid); end
        @(negedge clk);
        n_cmp++; if (bus.rk_data !== 128'h62636363626363636263636362636363) begin n_err++; $display("FAIL rekey_rk1: got %h want 62636363626363636263636362636363", bus.rk_data); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.key   = FIPS_KEY;
        bus.start = 1'b1;
        repeat (11) @(negedge clk);
        n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL b2b_done_e10: got %b want 1", bus.done); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_e10: got %b want 0", bus.busy); end
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL b2b_restart_busy: got %b want 1", bus.busy); end
        n_cmp++; if (bus.keys_valid !== 1'b0) begin n_err++; $display("FAIL b2b_restart_kv: got %b want 0", bus.keys_valid); end
        repeat (10) @(negedge clk);
        n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL b2b_done2: got %b want 1", bus.done); end
        bus.rk_addr = 4'd10;
        @(negedge clk);
        n_cmp++; if (bus.rk_data !== fips_rk[10]) begin n_err++; $display("FAIL b2b_rk10: got %h want %h", bus.rk_data, fips_rk[10]); end
    endtask

    initial begin
        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        test_reset();
        test_fips();
        test_reverse_readout();
        test_start_while_busy();
        test_reset_mid();
        test_rekey();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/aes128_key_expand.md
# aes128_key_expand

Iterative AES-128 key-schedule unit sitting directly upstream of the AES-128 decryptor (`main`). It accepts a 128-bit cipher key, generates the eleven round keys (rounds 0..10) at one round key per clock, and holds them in an internal register file. The decryptor reads the keys by round index, last round first, through a registered read port.

## Interface
Parameters:
- None. Key width is fixed at 128 and round count at 10.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request expansion of `key`; sampled only while `busy`=0.
- `key`  in  [0:127]  cipher key; bit 0 is the MSB, byte 0 is `key[0:7]`.
- `busy`  out  1  high while round keys 1..10 are being generated.
- `done`  out  1  one-cycle pulse when round key 10 has been written.
- `keys_valid`  out  1  level: all 11 round keys are valid for the current key.
- `rk_addr`  in  4  round index to read, 0..10.
- `rk_data`  out  [0:127]  registered round key for `rk_addr`, with the same bit ordering as `key`.

## Operation
- Storage: `rk[0..10]`, 128 bits each. Round counter `cnt` is 4 bits.
- States: IDLE (`busy`=0) and EXPAND (`busy`=1).
- IDLE, `start`=1:
  - `rk[0]` <= `key`, `cnt` <= 1, `busy` <= 1, `keys_valid` <= 0.
- EXPAND, each edge:
  - `prev` = `rk[cnt-1]`, with words w0..w3 where w0 = `prev[0:31]`.
  - t = SubWord(RotWord(w3)) ^ {Rcon[cnt], 24'h0}.
  - New words: n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - `rk[cnt]` <= {n0,n1,n2,n3}, then `cnt` <= `cnt`+1.
- Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- SubWord applies the FIPS-197 forward S-box to each byte. The S-box is a combinational case table, with 4 instances.
- On the edge that writes `rk[10]`: `busy` <= 0, `done` <= 1, `keys_valid` <= 1. Otherwise `done` <= 0.
- `start` while `busy`=1 is ignored, with no restart and no queuing.
- `start` while `keys_valid`=1 is accepted. `keys_valid` drops on that edge, and the old keys are overwritten progressively.
- Read port, every edge:
  - `rk_data` <= `rk[rk_addr]` if `rk_addr` ≤ 10, else 128'h0.
  - Reads during EXPAND return the current array contents, with no blocking. The consumer must wait for `keys_valid`.
- `key` only needs to be stable on the `start`-sampling edge.

## Timing
- Reset (`reset`=1 at an edge):
  - `busy`=0, `done`=0, `keys_valid`=0, `rk_data`=0, `cnt`=0.
  - All `rk[i]` are cleared to 0.
  - Reset dominates `start` in the same cycle.
- Reset mid-EXPAND aborts the expansion. No `done` is produced, and `keys_valid` stays 0.
- Latency, with E0 = the edge sampling `start`:
  - `busy` is high after E0.
  - `rk[i]` is written at edge E0+i for i = 1..10.
  - `done` and `keys_valid` are high after E0+10, so `done` is high for the single cycle between E0+10 and E0+11.
  - The earliest next `start` is accepted at E0+10+1.
- Read latency is 1 cycle: an address presented before edge E appears on `rk_data` after E.
- `start` held high continuously restarts immediately after each completion: the accept edge is the one after `done` rises.

## Test plan
- Reset: assert `reset` for 2 cycles with `start`=1 → `busy`=`done`=`keys_valid`=0 and `rk_data`=0. `rk_addr`=0..10 all read 0 after reset release.
- FIPS-197 vector, `key`=2b7e151628aed2a6abf7158809cf4f3c:
  - `done` pulses exactly once, 10 edges after `start`.
  - `rk_addr`=0 → 2b7e151628aed2a6abf7158809cf4f3c.
  - `rk_addr`=1 → a0fafe1788542cb123a339392a6c7605.
  - `rk_addr`=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
- Reverse-order readout: after `keys_valid`, sweep `rk_addr` 10→0 on consecutive cycles → `rk_data` follows one cycle behind, matching the reference model. `rk_addr`=15 → 0.
- Start while busy: pulse `start` with `key`=0 at E0+3 during the FIPS expansion → it is ignored, and the result still matches the FIPS vector.
- Reset mid-expansion: assert `reset` at E0+5 → all outputs are 0 and no `done`. A new `start` with `key`=000102030405060708090a0b0c0d0e0f gives `rk[10]`=13111d7fe3944a17f307a78b4d2b30c5.
- Re-key: with `keys_valid`=1, start `key`=0 → `keys_valid` drops on the accept edge and `rk[1]`=62636363626363636263636362636363. `done` and `keys_valid` reassert after 10 edges.
